// File: rtl/multichannel_updowncounter_pkg.sv
// -----------------------------------------------------------------------------
// updowncounter_pkg
// Shared definitions for the multi-channel up/down counter:
//   op_e    - command opcode encoding carried on cmd_op
//   chan_w  - width of a channel-select field for a given channel count
// -----------------------------------------------------------------------------
package updowncounter_pkg;

   typedef enum logic [1:0] {
      OP_UP          = 2'b00,
      OP_DOWN        = 2'b01,
      OP_LOAD        = 2'b10,
      OP_CLEAR_FLAGS = 2'b11
   } op_e;

   // A single channel still gets a one-bit select so the ports never collapse
   // to zero width.
   function automatic int chan_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multichannel_updowncounter_if.sv
// -----------------------------------------------------------------------------
// multichannel_updowncounter_if
// Command handshake bundle between the instruction decoder (master) and the
// counter block (slave).
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  block accepts commands
//   cmd_op     master->slave  opcode (updowncounter_pkg::op_e encoding)
//   cmd_chan   master->slave  target channel
//   cmd_data   master->slave  load value, low bits are the UP/DOWN step
// -----------------------------------------------------------------------------
interface multichannel_updowncounter_if #(
   parameter int WIDTH  = 32,
   parameter int CHAN_W = 2
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [CHAN_W-1:0] cmd_chan;
   logic [WIDTH-1:0]  cmd_data;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_chan,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_chan,
      input  cmd_data,
      output cmd_ready
   );

endinterface

// File: rtl/multichannel_updowncounter_lane.sv
// -----------------------------------------------------------------------------
// updowncounter_lane
// One counter channel: count register, wrap/saturate arithmetic and the two
// sticky flags.
//   clock, reset_n  clock and asynchronous active-low reset
//   en              apply op this edge (command accepted for this lane)
//   op              operation to apply
//   step            UP/DOWN increment, zero-extended to the counter width
//   load_data       LOAD value
//   count           current counter value
//   ovf, unf        sticky overflow / underflow flags
//   evt             combinational: op would change count or over/underflow
// -----------------------------------------------------------------------------
module updowncounter_lane
   import updowncounter_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               STEP_WIDTH  = 8,
   parameter bit               SATURATE    = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  en,
   input  op_e                   op,
   input  logic [STEP_WIDTH-1:0] step,
   input  logic [WIDTH-1:0]      load_data,
   output logic [WIDTH-1:0]      count,
   output logic                  ovf,
   output logic                  unf,
   output logic                  evt
);

   localparam int PAD = WIDTH + 1 - STEP_WIDTH;

   logic [WIDTH:0]   step_x;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] count_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;

   // Carry/borrow land in bit WIDTH of the extended result.
   function automatic logic [WIDTH-1:0] fit_up(input logic [WIDTH:0] s);
      if (SATURATE && s[WIDTH]) return '1;
      return s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] fit_down(input logic [WIDTH:0] d);
      if (SATURATE && d[WIDTH]) return '0;
      return d[WIDTH-1:0];
   endfunction

   assign step_x = {{PAD{1'b0}}, step};
   assign sum    = {1'b0, count} + step_x;
   assign diff   = {1'b0, count} - step_x;

   always_comb begin
      count_nxt = count;
      ovf_nxt   = ovf;
      unf_nxt   = unf;
      evt       = 1'b0;
      case (op)
         OP_UP: begin
            count_nxt = fit_up(sum);
            ovf_nxt   = ovf | sum[WIDTH];
            // A clamped counter still reports the overflow it absorbed.
            evt       = sum[WIDTH] | (count_nxt != count);
         end
         OP_DOWN: begin
            count_nxt = fit_down(diff);
            unf_nxt   = unf | diff[WIDTH];
            evt       = diff[WIDTH] | (count_nxt != count);
         end
         OP_LOAD: begin
            count_nxt = load_data;
            evt       = (load_data != count);
         end
         OP_CLEAR_FLAGS: begin
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   // --- stage p1: lane state register ---
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= RESET_VALUE;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (en) begin
         count <= count_nxt;
         ovf   <= ovf_nxt;
         unf   <= unf_nxt;
      end
   end

endmodule

// File: rtl/multichannel_updowncounter.sv
// -----------------------------------------------------------------------------
// multichannel_updowncounter
// CHANNELS independent WIDTH-bit up/down counters, one channel updated per
// accepted command, with sticky overflow/underflow flags, an event pulse and a
// registered readback port.
//   clock, reset_n  clock and asynchronous active-low reset
//   cmd             command handshake (slave side)
//   value           packed live counters, channel 0 in the LSBs
//   ovf_flag        sticky overflow per channel
//   unf_flag        sticky underflow per channel
//   evt_valid       one-cycle pulse: a counter changed or wrapped/clamped
//   evt_chan        channel of the last event
//   cmd_err         one-cycle pulse: accepted command addressed a missing channel
//   rd_chan         readback select
//   rd_value        registered readback (pre-update value on same-cycle write)
// -----------------------------------------------------------------------------
module multichannel_updowncounter
   import updowncounter_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               CHANNELS    = 4,
   parameter int               STEP_WIDTH  = 8,
   parameter int               SATURATE    = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int              CHAN_W      = chan_w(CHANNELS)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   multichannel_updowncounter_if.slave cmd,
   output logic [CHANNELS*WIDTH-1:0]   value,
   output logic [CHANNELS-1:0]         ovf_flag,
   output logic [CHANNELS-1:0]         unf_flag,
   output logic                        evt_valid,
   output logic [CHAN_W-1:0]           evt_chan,
   output logic                        cmd_err,
   input  logic [CHAN_W-1:0]           rd_chan,
   output logic [WIDTH-1:0]            rd_value
);

   logic                  ready_p1;
   logic                  accept;
   logic                  in_range;
   logic                  evt_sel;
   logic [WIDTH-1:0]      rd_sel;
   op_e                   op;
   logic [CHANNELS-1:0]   lane_en;
   logic [CHANNELS-1:0]   lane_evt;
   logic [WIDTH-1:0]      count_w [CHANNELS];

   assign accept   = cmd.cmd_valid & ready_p1;
   // One extra bit so CHANNELS itself is representable in the compare.
   assign in_range = ({1'b0, cmd.cmd_chan} < (CHAN_W + 1)'(CHANNELS));
   assign op       = op_e'(cmd.cmd_op);
   assign cmd.cmd_ready = ready_p1;

   genvar c;
   generate
      for (c = 0; c < CHANNELS; c++) begin : g_lane
         assign lane_en[c] = accept & (cmd.cmd_chan == CHAN_W'(c));

         updowncounter_lane #(
            .WIDTH       (WIDTH),
            .STEP_WIDTH  (STEP_WIDTH),
            .SATURATE    (SATURATE != 0),
            .RESET_VALUE (RESET_VALUE)
         ) u_lane (
            .clock     (clock),
            .reset_n   (reset_n),
            .en        (lane_en[c]),
            .op        (op),
            .step      (cmd.cmd_data[STEP_WIDTH-1:0]),
            .load_data (cmd.cmd_data),
            .count     (count_w[c]),
            .ovf       (ovf_flag[c]),
            .unf       (unf_flag[c]),
            .evt       (lane_evt[c])
         );

         assign value[c*WIDTH +: WIDTH] = count_w[c];
      end
   endgenerate

   // Out-of-range selects match no lane and fall through to the defaults.
   always_comb begin
      evt_sel = 1'b0;
      rd_sel  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cmd.cmd_chan == CHAN_W'(i)) evt_sel = lane_evt[i];
         if (rd_chan == CHAN_W'(i))      rd_sel  = count_w[i];
      end
   end

   // --- stage p1: handshake, event, error and readback registers ---
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_p1  <= 1'b0;
         evt_valid <= 1'b0;
         evt_chan  <= '0;
         cmd_err   <= 1'b0;
         rd_value  <= '0;
      end else begin
         ready_p1  <= 1'b1;
         evt_valid <= accept & in_range & evt_sel;
         cmd_err   <= accept & ~in_range;
         rd_value  <= rd_sel;
         if (accept & in_range & evt_sel) evt_chan <= cmd.cmd_chan;
      end
   end

endmodule

// File: tb/tb_multichannel_updowncounter.sv
// -----------------------------------------------------------------------------
// tb_multichannel_updowncounter
// Directed bench for two configurations:
//   dut_a  WIDTH=8 CHANNELS=4 STEP_WIDTH=8 wrap     RESET_VALUE=5
//   dut_b  WIDTH=8 CHANNELS=3 STEP_WIDTH=4 saturate RESET_VALUE=0
// -----------------------------------------------------------------------------
module tb_multichannel_updowncounter;

   localparam logic [1:0] UP = 2'b00, DN = 2'b01, LD = 2'b10, CLR = 2'b11;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   multichannel_updowncounter_if #(.WIDTH(8), .CHAN_W(2)) if_a ();
   multichannel_updowncounter_if #(.WIDTH(8), .CHAN_W(2)) if_b ();

   logic [31:0] value_a;
   logic [3:0]  ovf_a, unf_a;
   logic        evt_a, err_a;
   logic [1:0]  evt_chan_a, rd_chan_a;
   logic [7:0]  rd_a;

   logic [23:0] value_b;
   logic [2:0]  ovf_b, unf_b;
   logic        evt_b, err_b;
   logic [1:0]  evt_chan_b, rd_chan_b;
   logic [7:0]  rd_b;

   multichannel_updowncounter #(
      .WIDTH(8), .CHANNELS(4), .STEP_WIDTH(8), .SATURATE(0), .RESET_VALUE(8'h05)
   ) dut_a (
      .clock(clock), .reset_n(reset_n), .cmd(if_a),
      .value(value_a), .ovf_flag(ovf_a), .unf_flag(unf_a),
      .evt_valid(evt_a), .evt_chan(evt_chan_a), .cmd_err(err_a),
      .rd_chan(rd_chan_a), .rd_value(rd_a)
   );

   multichannel_updowncounter #(
      .WIDTH(8), .CHANNELS(3), .STEP_WIDTH(4), .SATURATE(1), .RESET_VALUE(8'h00)
   ) dut_b (
      .clock(clock), .reset_n(reset_n), .cmd(if_b),
      .value(value_b), .ovf_flag(ovf_b), .unf_flag(unf_b),
      .evt_valid(evt_b), .evt_chan(evt_chan_b), .cmd_err(err_b),
      .rd_chan(rd_chan_b), .rd_value(rd_b)
   );

   // Called at posedge+1; returns at posedge+1 after the command's edge.
   task automatic cmd_a(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] d);
      if_a.cmd_valid = 1'b1; if_a.cmd_op = op; if_a.cmd_chan = ch; if_a.cmd_data = d;
      @(posedge clock); #1;
      if_a.cmd_valid = 1'b0;
   endtask

   task automatic cmd_b(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] d);
      if_b.cmd_valid = 1'b1; if_b.cmd_op = op; if_b.cmd_chan = ch; if_b.cmd_data = d;
      @(posedge clock); #1;
      if_b.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++; if (value_a !== 32'h0505_0505) begin failures++; $display("FAIL reset_value_a got=%h exp=%h", value_a, 32'h0505_0505); end
      checks++; if (value_b !== 24'h00_0000) begin failures++; $display("FAIL reset_value_b got=%h exp=%h", value_b, 24'h0); end
      checks++; if ({if_a.cmd_ready, if_b.cmd_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {if_a.cmd_ready, if_b.cmd_ready}); end
      checks++; if ({ovf_a, unf_a, evt_a, err_a, evt_chan_a, rd_a} !== '0) begin failures++; $display("FAIL reset_ctrl_a got=%h exp=0", {ovf_a, unf_a, evt_a, err_a, evt_chan_a, rd_a}); end
      reset_n = 1'b1;
      #1;
      checks++; if (if_a.cmd_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b exp=0", if_a.cmd_ready); end
      @(posedge clock); #1;
      checks++; if ({if_a.cmd_ready, if_b.cmd_ready} !== 2'b11) begin failures++; $display("FAIL ready_after_edge got=%b exp=11", {if_a.cmd_ready, if_b.cmd_ready}); end
   endtask

   task automatic test_wrap();
      cmd_a(LD, 2'd1, 8'hFE);
      checks++; if (value_a !== 32'h0505_FE05) begin failures++; $display("FAIL load_value got=%h exp=%h", value_a, 32'h0505_FE05); end
      checks++; if ({evt_a, evt_chan_a} !== 3'b1_01) begin failures++; $display("FAIL load_evt got=%b exp=101", {evt_a, evt_chan_a}); end
      cmd_a(UP, 2'd1, 8'h03);
      checks++; if (value_a !== 32'h0505_0105) begin failures++; $display("FAIL wrap_value got=%h exp=%h", value_a, 32'h0505_0105); end
      checks++; if ({ovf_a, unf_a} !== 8'b0010_0000) begin failures++; $display("FAIL wrap_flags got=%b exp=00100000", {ovf_a, unf_a}); end
      checks++; if ({evt_a, evt_chan_a} !== 3'b1_01) begin failures++; $display("FAIL wrap_evt got=%b exp=101", {evt_a, evt_chan_a}); end
      @(posedge clock); #1;
      checks++; if (evt_a !== 1'b0) begin failures++; $display("FAIL evt_one_cycle got=%b exp=0", evt_a); end
      cmd_a(UP, 2'd0, 8'h00);
      checks++; if ({value_a, evt_a} !== {32'h0505_0105, 1'b0}) begin failures++; $display("FAIL step0 got=%h/%b exp=05050105/0", value_a, evt_a); end
      cmd_a(LD, 2'd0, 8'h05);
      checks++; if (evt_a !== 1'b0) begin failures++; $display("FAIL load_same_no_evt got=%b exp=0", evt_a); end
   endtask

   task automatic test_saturate();
      cmd_b(LD, 2'd0, 8'h02);
      cmd_b(DN, 2'd0, 8'h05);
      checks++; if ({value_b[7:0], unf_b[0], evt_b} !== {8'h00, 1'b1, 1'b1}) begin failures++; $display("FAIL sat_down got=%h/%b/%b exp=00/1/1", value_b[7:0], unf_b[0], evt_b); end
      cmd_b(DN, 2'd0, 8'h01);
      checks++; if ({value_b[7:0], unf_b[0], evt_b, evt_chan_b} !== {8'h00, 1'b1, 1'b1, 2'd0}) begin failures++; $display("FAIL sat_down_again got=%h/%b/%b/%0d exp=00/1/1/0", value_b[7:0], unf_b[0], evt_b, evt_chan_b); end
      cmd_b(LD, 2'd1, 8'hFE);
      cmd_b(UP, 2'd1, 8'hAF);
      checks++; if ({value_b, ovf_b, unf_b} !== {24'h00FF00, 3'b010, 3'b001}) begin failures++; $display("FAIL sat_up got=%h/%b/%b exp=00ff00/010/001", value_b, ovf_b, unf_b); end
   endtask

   task automatic test_readback();
      rd_chan_a = 2'd2;
      cmd_a(UP, 2'd2, 8'h01);
      checks++; if ({rd_a, value_a[23:16]} !== {8'h05, 8'h06}) begin failures++; $display("FAIL rd_same_cycle got=%h/%h exp=05/06", rd_a, value_a[23:16]); end
      @(posedge clock); #1;
      checks++; if (rd_a !== 8'h06) begin failures++; $display("FAIL rd_next_cycle got=%h exp=06", rd_a); end
      cmd_a(LD, 2'd2, 8'h00);
      cmd_a(DN, 2'd2, 8'h01);
      checks++; if ({value_a[23:16], unf_a} !== {8'hFF, 4'b0100}) begin failures++; $display("FAIL wrap_down got=%h/%b exp=ff/0100", value_a[23:16], unf_a); end
      cmd_a(CLR, 2'd2, 8'h00);
      checks++; if ({ovf_a, unf_a, evt_a, value_a} !== {4'b0010, 4'b0000, 1'b0, 32'h05FF_0105}) begin failures++; $display("FAIL clear_flags got=%b/%b/%b/%h exp=0010/0000/0/05ff0105", ovf_a, unf_a, evt_a, value_a); end
      rd_chan_b = 2'd3;
      @(posedge clock); #1;
      checks++; if (rd_b !== 8'h00) begin failures++; $display("FAIL rd_out_of_range got=%h exp=00", rd_b); end
      rd_chan_b = 2'd1;
      @(posedge clock); #1;
      checks++; if (rd_b !== 8'hFF) begin failures++; $display("FAIL rd_b_ch1 got=%h exp=ff", rd_b); end
   endtask

   task automatic test_err();
      cmd_b(UP, 2'd3, 8'h01);
      checks++; if ({err_b, evt_b} !== 2'b10) begin failures++; $display("FAIL err_pulse got=%b exp=10", {err_b, evt_b}); end
      checks++; if ({value_b, ovf_b, unf_b} !== {24'h00FF00, 3'b010, 3'b001}) begin failures++; $display("FAIL err_no_change got=%h/%b/%b exp=00ff00/010/001", value_b, ovf_b, unf_b); end
      @(posedge clock); #1;
      checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", err_b); end
   endtask

   task automatic test_back_to_back();
      if_a.cmd_valid = 1'b1; if_a.cmd_chan = 2'd3;
      if_a.cmd_op = UP; if_a.cmd_data = 8'h01;
      @(posedge clock); #1;
      checks++; if (value_a[31:24] !== 8'h06) begin failures++; $display("FAIL b2b_1 got=%h exp=06", value_a[31:24]); end
      if_a.cmd_op = UP; if_a.cmd_data = 8'h02;
      @(posedge clock); #1;
      checks++; if (value_a[31:24] !== 8'h08) begin failures++; $display("FAIL b2b_2 got=%h exp=08", value_a[31:24]); end
      if_a.cmd_op = DN; if_a.cmd_data = 8'h01;
      @(posedge clock); #1;
      if_a.cmd_valid = 1'b0;
      checks++; if ({value_a[31:24], evt_a, evt_chan_a} !== {8'h07, 1'b1, 2'd3}) begin failures++; $display("FAIL b2b_3 got=%h/%b/%0d exp=07/1/3", value_a[31:24], evt_a, evt_chan_a); end
   endtask

   task automatic test_async_reset();
      if_a.cmd_valid = 1'b1; if_a.cmd_op = UP; if_a.cmd_chan = 2'd0; if_a.cmd_data = 8'h01;
      if_b.cmd_valid = 1'b1; if_b.cmd_op = UP; if_b.cmd_chan = 2'd0; if_b.cmd_data = 8'h01;
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if ({value_a, ovf_a, unf_a, if_a.cmd_ready} !== {32'h0505_0505, 9'h0}) begin failures++; $display("FAIL async_reset_a got=%h/%b/%b/%b exp=05050505/0/0/0", value_a, ovf_a, unf_a, if_a.cmd_ready); end
      checks++; if ({value_b, ovf_b, unf_b} !== 30'h0) begin failures++; $display("FAIL async_reset_b got=%h/%b/%b exp=0", value_b, ovf_b, unf_b); end
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      if_a.cmd_valid = 1'b0; if_b.cmd_valid = 1'b0;
      checks++; if ({value_a, evt_a, if_a.cmd_ready} !== {32'h0505_0505, 1'b0, 1'b1}) begin failures++; $display("FAIL after_reset got=%h/%b/%b exp=05050505/0/1", value_a, evt_a, if_a.cmd_ready); end
   endtask

   initial begin
      if_a.cmd_valid = 1'b0; if_a.cmd_op = UP; if_a.cmd_chan = '0; if_a.cmd_data = '0;
      if_b.cmd_valid = 1'b0; if_b.cmd_op = UP; if_b.cmd_chan = '0; if_b.cmd_data = '0;
      rd_chan_a = '0; rd_chan_b = '0;
      test_reset();
      test_wrap();
      test_saturate();
      test_readback();
      test_err();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
